// File: rtl/scpad_req_arbiter.sv
// scpad_req_arbiter: shares one scratchpad pipeline between the frontend (FE)
// and backend (BE) requesters. Grants are registered into a single-entry output
// slot tagged with the source, in-flight responses are counted per source with
// a credit limit, a starvation counter forces a waiting BE through, and a
// RUN/DRAIN/DONE/HOLD sequence implements flush.
// Optional build macro: SCPAD_ARB_PERF_EN adds grant and stall counters.
module scpad_req_arbiter #(
  parameter int IDX             = 0,
  parameter int ADDR_W          = 16,
  parameter int DATA_W          = 128,
  parameter int MAX_OUTSTANDING = 4,
  parameter int STARVE_LIMIT    = 8,
  localparam int CNT_W          = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fe_req_valid,
  output logic              fe_req_ready,
  input  logic              fe_req_write,
  input  logic [ADDR_W-1:0] fe_req_addr,
  input  logic [DATA_W-1:0] fe_req_wdata,
  input  logic              be_req_valid,
  output logic              be_req_ready,
  input  logic              be_req_write,
  input  logic [ADDR_W-1:0] be_req_addr,
  input  logic [DATA_W-1:0] be_req_wdata,
  output logic              pipe_req_valid,
  input  logic              pipe_req_ready,
  output logic              pipe_req_src,
  output logic              pipe_req_write,
  output logic [ADDR_W-1:0] pipe_req_addr,
  output logic [DATA_W-1:0] pipe_req_wdata,
  input  logic              rsp_valid,
  input  logic              rsp_src,
  input  logic              flush_req,
  output logic              flush_done,
  output logic [CNT_W-1:0]  fe_outstanding,
  output logic [CNT_W-1:0]  be_outstanding,
  output logic              err_underflow
`ifdef SCPAD_ARB_PERF_EN
  ,
  output logic [31:0]       perf_fe_grants,
  output logic [31:0]       perf_be_grants,
  output logic [31:0]       perf_stall_cycles
`endif
);

  localparam int SCPAD_ID_WIDTH = 4;
  localparam int SW             = $clog2(STARVE_LIMIT + 1);

  // Elaboration-time parameter sanity checks.
  if (IDX < 0 || IDX >= (1 << SCPAD_ID_WIDTH)) begin : g_bad_idx
    $error("scpad_req_arbiter: IDX out of range");
  end
  if (MAX_OUTSTANDING < 1 || STARVE_LIMIT < 1) begin : g_bad_limits
    $error("scpad_req_arbiter: MAX_OUTSTANDING and STARVE_LIMIT must be >= 1");
  end

  typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_DONE, ST_HOLD} state_t;

  state_t        state_reg, state_next;
  logic [SW-1:0] starve_reg;
  logic          slot_free;
  logic          be_force;
  logic          fe_grant, be_grant;
  logic [1:0]    req_valid, grant, dec;

  assign slot_free = !pipe_req_valid || pipe_req_ready;
  assign req_valid = {be_req_valid, fe_req_valid};
  assign grant     = {be_grant, fe_grant};
  assign dec       = {rsp_valid & rsp_src, rsp_valid & ~rsp_src};

  // Per-source credit tracking: index 0 = FE, index 1 = BE.
  for (genvar gi = 0; gi < 2; gi++) begin : g_src
    logic [CNT_W-1:0] cnt_reg;
    logic             uf_reg;
    logic             elig;

    assign elig = req_valid[gi] && (cnt_reg < CNT_W'(MAX_OUTSTANDING)) &&
                  (state_reg == ST_RUN) && slot_free;

    // In-flight count: +1 on grant, -1 on response, sticky underflow flag.
    always_ff @(posedge clk) begin
      if (rst) begin
        cnt_reg <= '0;
        uf_reg  <= 1'b0;
      end else if (grant[gi] && !dec[gi]) begin
        cnt_reg <= cnt_reg + CNT_W'(1);
      end else if (!grant[gi] && dec[gi]) begin
        if (cnt_reg == '0) uf_reg <= 1'b1;
        else cnt_reg <= cnt_reg - CNT_W'(1);
      end
    end
  end

  assign fe_outstanding = g_src[0].cnt_reg;
  assign be_outstanding = g_src[1].cnt_reg;
  assign err_underflow  = g_src[0].uf_reg | g_src[1].uf_reg;

  // FE has priority unless BE has lost STARVE_LIMIT consecutive arbitrations.
  assign be_force     = (starve_reg == SW'(STARVE_LIMIT));
  assign be_grant     = g_src[1].elig && (!g_src[0].elig || be_force);
  assign fe_grant     = g_src[0].elig && !be_grant;
  assign fe_req_ready = fe_grant;
  assign be_req_ready = be_grant;

  // Starvation counter: counts cycles an eligible BE loses, saturating.
  always_ff @(posedge clk) begin
    if (rst || !be_req_valid || be_grant) starve_reg <= '0;
    else if (g_src[1].elig && starve_reg != SW'(STARVE_LIMIT))
      starve_reg <= starve_reg + SW'(1);
  end

  // Single-entry output slot: loads on grant, empties when the pipeline takes it.
  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_req_valid <= 1'b0;
      pipe_req_src   <= 1'b0;
      pipe_req_write <= 1'b0;
      pipe_req_addr  <= '0;
      pipe_req_wdata <= '0;
    end else if (fe_grant || be_grant) begin
      pipe_req_valid <= 1'b1;
      pipe_req_src   <= be_grant;
      pipe_req_write <= be_grant ? be_req_write : fe_req_write;
      pipe_req_addr  <= be_grant ? be_req_addr  : fe_req_addr;
      pipe_req_wdata <= be_grant ? be_req_wdata : fe_req_wdata;
    end else if (pipe_req_ready) begin
      pipe_req_valid <= 1'b0;
    end
  end

  // Flush state register.
  always_ff @(posedge clk) begin
    if (rst) state_reg <= ST_RUN;
    else     state_reg <= state_next;
  end

  // Flush sequencing and the one-cycle completion pulse.
  always_comb begin
    state_next = state_reg;
    flush_done = 1'b0;
    case (state_reg)
      ST_RUN:   if (flush_req) state_next = ST_DRAIN;
      ST_DRAIN: if (!pipe_req_valid && fe_outstanding == '0 && be_outstanding == '0)
                  state_next = ST_DONE;
      ST_DONE: begin
        flush_done = 1'b1;
        state_next = flush_req ? ST_HOLD : ST_RUN;
      end
      ST_HOLD:  if (!flush_req) state_next = ST_RUN;
      default:  state_next = ST_RUN;
    endcase
  end

`ifdef SCPAD_ARB_PERF_EN
  // Free-running performance counters, wrapping at 2^32.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fe_grants    <= '0;
      perf_be_grants    <= '0;
      perf_stall_cycles <= '0;
    end else begin
      if (fe_grant) perf_fe_grants <= perf_fe_grants + 32'd1;
      if (be_grant) perf_be_grants <= perf_be_grants + 32'd1;
      if (pipe_req_valid && !pipe_req_ready) perf_stall_cycles <= perf_stall_cycles + 32'd1;
    end
  end
`endif

endmodule
